// File: rtl/misr_pkg.sv
// Shared types and defaults for the y-response signature compactor.
// Widths match the 53-bit `top.y` output folded into a 64-bit MISR.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } misr_state_e;

  localparam int          MISR_DATA_W      = 53;
  localparam int          MISR_SIG_W       = 64;
  localparam int          MISR_CNT_W       = 16;
  localparam int          MISR_NUM_SAMPLES = 16;
  localparam logic [63:0] MISR_POLY        = 64'h0000_0000_0000_001B;
  localparam logic [63:0] MISR_SEED        = 64'h0;

endpackage

// File: rtl/misr_core.sv
// Galois-form multiple-input signature register: shift left, fold the MSB
// back through POLY, and XOR in the zero-extended data word.
module misr_core
  import misr_pkg::*;
#(
  parameter int               SIG_W  = MISR_SIG_W,
  parameter int               DATA_W = MISR_DATA_W,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SIG_W-1:0]  seed,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_reg;
  logic [SIG_W-1:0] sig_next;
  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] fold;

  // Per-bit zero extension also covers the SIG_W == DATA_W case cleanly.
  generate
    for (genvar gi = 0; gi < SIG_W; gi++) begin : g_ext
      if (gi < DATA_W) begin : g_data
        assign data_ext[gi] = data[gi];
      end else begin : g_zero
        assign data_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign fold = {sig_reg[SIG_W-2:0], 1'b0}
              ^ (POLY & {SIG_W{sig_reg[SIG_W-1]}})
              ^ data_ext;

  always_comb begin
    sig_next = sig_reg;
    if (load) begin
      sig_next = seed;
    end else if (en) begin
      sig_next = fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/y_signature_misr.sv
// Samples top.y on qualified cycles, compacts NUM_SAMPLES words into a MISR
// signature and offers it on a valid/ready port until the harness takes it.
module y_signature_misr
  import misr_pkg::*;
#(
  parameter int               DATA_W      = MISR_DATA_W,
  parameter int               SIG_W       = MISR_SIG_W,
  parameter logic [SIG_W-1:0] POLY        = SIG_W'(MISR_POLY),
  parameter logic [SIG_W-1:0] SEED        = SIG_W'(MISR_SEED),
  parameter int               NUM_SAMPLES = MISR_NUM_SAMPLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  sig_valid,
  input  logic                  sig_ready,
  output logic [SIG_W-1:0]      sig_data,
  output logic                  busy,
  output logic [MISR_CNT_W-1:0] sample_cnt,
  output logic                  dropped
);

  localparam logic [MISR_CNT_W-1:0] LAST_CNT = MISR_CNT_W'(NUM_SAMPLES);

  misr_state_e           state_reg, state_next;
  logic [MISR_CNT_W-1:0] cnt_reg, cnt_next;
  logic                  dropped_reg, dropped_next;
  logic                  load;
  logic                  accept;
  logic                  cnt_done;

  // start only acts from IDLE; samples only count while accumulating.
  assign load     = (state_reg == IDLE) && start;
  assign accept   = (state_reg == ACCUM) && in_valid;
  assign cnt_done = (cnt_reg + MISR_CNT_W'(1)) == LAST_CNT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (in_valid && cnt_done) state_next = HOLD;
      HOLD:    if (sig_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sig_valid = (state_reg == HOLD);
    busy      = (state_reg != IDLE);
  end

  always_comb begin
    cnt_next     = cnt_reg;
    dropped_next = dropped_reg;
    if (load) begin
      cnt_next     = '0;
      dropped_next = 1'b0;
    end else if (accept) begin
      cnt_next = cnt_reg + MISR_CNT_W'(1);
    end else if ((state_reg == HOLD) && in_valid) begin
      dropped_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      dropped_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      dropped_reg <= dropped_next;
    end
  end

  assign sample_cnt = cnt_reg;
  assign dropped    = dropped_reg;

  misr_core #(
    .SIG_W  (SIG_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .seed  (SEED),
    .en    (accept),
    .data  (in_data),
    .sig   (sig_data)
  );

endmodule

// File: tb/tb_y_signature_misr.sv
// Bench for y_signature_misr: table vectors, directed corner sequences and a
// randomized run checked against a queue-based signature model.
module tb_y_signature_misr;

  localparam logic [63:0] POLY   = 64'h1B;
  localparam logic [63:0] SEED_B = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SEED_C = 64'hA5A5_0000_1234_5678;
  localparam int          NUM_C  = 4;

  logic clk, rst_n;

  // Instance a: NUM_SAMPLES=2, SEED=0
  logic        a_start, a_in_valid, a_sig_ready, a_sig_valid, a_busy, a_dropped;
  logic [52:0] a_in_data;
  logic [63:0] a_sig_data;
  logic [15:0] a_sample_cnt;
  // Instance b: NUM_SAMPLES=1, SEED=MSB set
  logic        b_start, b_in_valid, b_sig_ready, b_sig_valid, b_busy, b_dropped;
  logic [52:0] b_in_data;
  logic [63:0] b_sig_data;
  logic [15:0] b_sample_cnt;
  // Instance c: NUM_SAMPLES=4, nonzero SEED
  logic        c_start, c_in_valid, c_sig_ready, c_sig_valid, c_busy, c_dropped;
  logic [52:0] c_in_data;
  logic [63:0] c_sig_data;
  logic [15:0] c_sample_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  y_signature_misr #(.POLY(POLY), .SEED(64'h0), .NUM_SAMPLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
    .in_data(a_in_data), .sig_valid(a_sig_valid), .sig_ready(a_sig_ready),
    .sig_data(a_sig_data), .busy(a_busy), .sample_cnt(a_sample_cnt),
    .dropped(a_dropped));

  y_signature_misr #(.POLY(POLY), .SEED(SEED_B), .NUM_SAMPLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
    .in_data(b_in_data), .sig_valid(b_sig_valid), .sig_ready(b_sig_ready),
    .sig_data(b_sig_data), .busy(b_busy), .sample_cnt(b_sample_cnt),
    .dropped(b_dropped));

  y_signature_misr #(.POLY(POLY), .SEED(SEED_C), .NUM_SAMPLES(NUM_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_in_valid),
    .in_data(c_in_data), .sig_valid(c_sig_valid), .sig_ready(c_sig_ready),
    .sig_data(c_sig_data), .busy(c_busy), .sample_cnt(c_sample_cnt),
    .dropped(c_dropped));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [52:0] rand53();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[52:0];
  endfunction

  // One signature step straight from the arithmetic rule.
  function automatic logic [63:0] misr_fold(input logic [63:0] s, input logic [52:0] d);
    return (s << 1) ^ (s[63] ? POLY : 64'h0) ^ {11'b0, d};
  endfunction

  // Reference model for instance c: the run is the list of accepted words.
  logic [52:0] m_acc[$];
  bit          m_run, m_started, m_drop;

  function automatic logic [63:0] m_sig();
    logic [63:0] s;
    if (!m_started) return 64'h0;
    s = SEED_C;
    foreach (m_acc[i]) s = misr_fold(s, m_acc[i]);
    return s;
  endfunction

  task automatic model_reset();
    m_acc.delete();
    m_run = 0; m_started = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit s, input bit iv, input logic [52:0] d, input bit r);
    if (!m_run) begin
      if (s) begin
        m_run = 1; m_started = 1; m_drop = 0;
        m_acc.delete();
      end
    end else if (m_acc.size() < NUM_C) begin
      if (iv) m_acc.push_back(d);
    end else begin
      if (iv) m_drop = 1;
      if (r) m_run = 0;
    end
  endtask

  task automatic model_check();
    bit full;
    full = m_run && (m_acc.size() == NUM_C);
    check($sformatf("c_valid@%0d", cyc), {63'b0, c_sig_valid}, {63'b0, full});
    check($sformatf("c_busy@%0d", cyc), {63'b0, c_busy}, {63'b0, m_run});
    check($sformatf("c_cnt@%0d", cyc), {48'b0, c_sample_cnt}, 64'(m_acc.size()));
    check($sformatf("c_drop@%0d", cyc), {63'b0, c_dropped}, {63'b0, m_drop});
    check($sformatf("c_sig@%0d", cyc), c_sig_data, m_sig());
  endtask

  task automatic c_cycle(input bit s, input bit iv, input logic [52:0] d, input bit r);
    c_start = s; c_in_valid = iv; c_in_data = d; c_sig_ready = r;
    model_step(s, iv, d, r);
    tick();
    model_check();
  endtask

  typedef struct {
    bit          start;
    bit          iv;
    logic [52:0] data;
    bit          ready;
    bit          e_valid;
    bit          e_busy;
    bit          e_drop;
    logic [63:0] e_sig;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit iv, input logic [52:0] d, input bit r,
                              input bit ev, input bit eb, input bit ed,
                              input logic [63:0] es, input logic [15:0] ec);
    vec_t v;
    v.start = s; v.iv = iv; v.data = d; v.ready = r;
    v.e_valid = ev; v.e_busy = eb; v.e_drop = ed; v.e_sig = es; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    rst_n = 1'b0;
    {a_start, a_in_valid, a_sig_ready} = '0; a_in_data = '0;
    {b_start, b_in_valid, b_sig_ready} = '0; b_in_data = '0;
    {c_start, c_in_valid, c_sig_ready} = '0; c_in_data = '0;
    model_reset();

    //           st iv data  rdy  val busy drop sig    cnt
    tbl[0]  = mk(1, 0, 53'd0, 0,  0,  1,   0,   64'h0, 16'd0);
    tbl[1]  = mk(0, 1, 53'd1, 0,  0,  1,   0,   64'h1, 16'd1);
    tbl[2]  = mk(0, 1, 53'd0, 0,  1,  1,   0,   64'h2, 16'd2);
    for (int i = 3; i <= 7; i++)
      tbl[i] = mk(0, 0, 53'd0, 0, 1,  1,   0,   64'h2, 16'd2);
    tbl[8]  = mk(0, 0, 53'd0, 1,  0,  0,   0,   64'h2, 16'd2);
    tbl[9]  = mk(1, 1, 53'h1F, 0, 0,  1,   0,   64'h0, 16'd0);
    tbl[10] = mk(1, 1, 53'd3, 0,  0,  1,   0,   64'h3, 16'd1);
    tbl[11] = mk(1, 0, 53'd0, 0,  0,  1,   0,   64'h3, 16'd1);
    tbl[12] = mk(0, 1, 53'd5, 0,  1,  1,   0,   64'h3, 16'd2);
    tbl[13] = mk(0, 1, 53'd7, 0,  1,  1,   1,   64'h3, 16'd2);
    tbl[14] = mk(0, 0, 53'd0, 1,  0,  0,   1,   64'h3, 16'd2);
    tbl[15] = mk(1, 0, 53'd0, 0,  0,  1,   0,   64'h0, 16'd0);
    tbl[16] = mk(0, 1, 53'd0, 0,  0,  1,   0,   64'h0, 16'd1);
    tbl[17] = mk(0, 1, 53'd0, 0,  1,  1,   0,   64'h0, 16'd2);
    tbl[18] = mk(0, 0, 53'd0, 1,  0,  0,   0,   64'h0, 16'd2);
    tbl[19] = mk(0, 1, 53'd9, 0,  0,  0,   0,   64'h0, 16'd2);

    #12;
    check("rst_a_sig", a_sig_data, 64'h0);
    check("rst_a_flags", {60'b0, a_sig_valid, a_busy, a_dropped, 1'b0}, 64'h0);
    check("rst_a_cnt", {48'b0, a_sample_cnt}, 64'h0);
    model_check();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven run on instance a
    for (int i = 0; i < 20; i++) begin
      a_start = tbl[i].start; a_in_valid = tbl[i].iv;
      a_in_data = tbl[i].data; a_sig_ready = tbl[i].ready;
      tick();
      check($sformatf("a_valid[%0d]", i), {63'b0, a_sig_valid}, {63'b0, tbl[i].e_valid});
      check($sformatf("a_busy[%0d]", i), {63'b0, a_busy}, {63'b0, tbl[i].e_busy});
      check($sformatf("a_drop[%0d]", i), {63'b0, a_dropped}, {63'b0, tbl[i].e_drop});
      check($sformatf("a_sig[%0d]", i), a_sig_data, tbl[i].e_sig);
      check($sformatf("a_cnt[%0d]", i), {48'b0, a_sample_cnt}, {48'b0, tbl[i].e_cnt});
    end
    {a_start, a_in_valid, a_sig_ready} = '0;

    // Feedback path on instance b: one zero sample from an MSB-set seed
    b_start = 1; tick(); b_start = 0;
    check("b_seed", b_sig_data, SEED_B);
    check("b_busy", {63'b0, b_busy}, 64'h1);
    b_in_valid = 1; b_in_data = '0; tick(); b_in_valid = 0;
    check("b_sig", b_sig_data, 64'h1B);
    check("b_valid", {63'b0, b_sig_valid}, 64'h1);
    check("b_cnt", {48'b0, b_sample_cnt}, 64'h1);
    b_sig_ready = 1; tick(); b_sig_ready = 0;
    check("b_drain", {62'b0, b_sig_valid, b_busy}, 64'h0);
    check("b_keep", b_sig_data, 64'h1B);

    // Gaps: samples on cycles 1,3,4,7 after start, then a drop in HOLD
    c_cycle(1, 0, '0, 0);
    for (int k = 1; k <= 7; k++) begin
      bit v;
      v = (k == 1) || (k == 3) || (k == 4) || (k == 7);
      c_cycle(0, v, rand53(), 0);
    end
    c_cycle(0, 1, rand53(), 0);
    c_cycle(0, 0, '0, 1);
    c_cycle(1, 0, '0, 0);
    c_cycle(0, 1, rand53(), 0);
    c_cycle(0, 1, rand53(), 0);

    // Asynchronous reset between edges, mid-ACCUM
    c_start = 0; c_in_valid = 0; c_sig_ready = 0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_c_sig", c_sig_data, 64'h0);
    check("arst_c_flags", {61'b0, c_sig_valid, c_busy, c_dropped}, 64'h0);
    check("arst_c_cnt", {48'b0, c_sample_cnt}, 64'h0);
    check("arst_b_sig", b_sig_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    c_cycle(1, 0, '0, 0);
    for (int k = 0; k < NUM_C; k++) c_cycle(0, 1, rand53(), 0);
    c_cycle(0, 0, '0, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      c_cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
              rand53(), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
